if_stage: RTL
=============

// Module: if_stage
// PURPOSE
//  Instruction-fetch stage of the CPCPU4 pipeline; sits directly upstream of the instruction ROM and feeds the ID stage.
//  Holds the PC, drives the ROM word address, and captures the returned instruction into the IF/ID pipeline register.
//  Resolves unconditional jumps (opcode 6'h12) in IF with no bubble.
//  Accepts stall from the hazard unit and redirect (taken branch) from EX.
// PARAMETERS
//  ADDR_W    6      ROM word-address width; rom_addr = pc[ADDR_W-1:0]
//  RESET_PC  32'h0  PC value after reset; word 0 holds a NOP
// PORTS
//  clk            in   1   rising-edge clock
//  rst            in   1   asynchronous, active-high reset
//  rom_addr       out  6   word address to instruction ROM (combinational from pc)
//  rom_inst       in   32  instruction from ROM, same cycle (combinational ROM)
//  stall          in   1   hold PC and IF/ID register
//  redirect_valid in   1   taken branch from EX; flushes IF/ID
//  redirect_pc    in   32  branch target (word address)
//  pc             out  32  current fetch PC
//  if_id_inst     out  32  latched instruction
//  if_id_pc       out  32  PC of latched instruction
//  if_id_pc_plus1 out  32  if_id_pc + 1, for branch offset calculation downstream
//  if_id_valid    out  1   latched instruction is real, not a bubble
//  if_id_jumped   out  1   latched instruction is a jump already resolved here; ID/EX must not redirect on it
//  fetch_count    out  32  number of valid instructions latched into IF/ID; saturates at 32'hFFFF_FFFF
// BEHAVIOUR
//  - Reset (async, any time incl. mid-stall or mid-redirect):
//      pc = RESET_PC.
//      if_id_inst = 32'h0, if_id_pc = 0, if_id_pc_plus1 = 0.
//      if_id_valid = 0, if_id_jumped = 0, fetch_count = 0.
//  - PC units are words: sequential next = pc + 1, wrapping mod 2^32.
//      rom_addr wraps mod 2^ADDR_W (pc 0x3F -> 0x40 gives rom_addr 0x00).
//  - is_jump = (rom_inst[31:26] == OP_JUMP).
//      jump_target = {pc[31:26], rom_inst[25:0]}.
//  - Per-edge priority (highest first):
//      1 redirect_valid: pc <= redirect_pc.
//          IF/ID <= bubble (inst 0, valid 0, jumped 0). pc/pc_plus1 fields hold.
//          Overrides stall and any jump in IF.
//      2 stall: pc and all IF/ID fields hold. fetch_count holds.
//      3 otherwise:
//          IF/ID <= {rom_inst, pc, pc+1, valid 1, jumped is_jump}.
//          pc <= is_jump ? jump_target : pc + 1.
//          fetch_count += 1 (saturating).
//  - Latency: an instruction at PC p appears on if_id_* one edge after pc == p with no stall.
//  - Jump penalty: 0 cycles. Branch penalty: 1 bubble per redirect from this stage.
//  - A jump whose target equals its own PC loops legally, producing one fetch per cycle.
//  - No state machine beyond PC and valid bit. All outputs are registered except rom_addr.
// STRUCTURE
//  - Shared package cpu_pkg holds:
//      OP_JUMP = 6'h12, NOP = 32'h0.
//      Opcode field range [31:26] and jump field range [25:0].
//      WORD_W = 32.
//  - One sub-module, if_pc_reg: PC register with async reset, next-PC mux and priority logic.
//      IF/ID register, predecode and counter stay in if_stage.
// TESTING
//  - Reset, then 3 clean edges:
//      rom_addr 0 -> 1 -> 2 -> 3.
//      if_id_pc = 2, if_id_inst = 32'h00101464, fetch_count = 3.
//  - pc = 7 with rom_inst = 32'h48000001:
//      next pc = 1.
//      if_id_inst = 32'h48000001, if_id_jumped = 1, if_id_valid = 1.
//  - stall held 4 cycles at pc = 5:
//      pc, if_id_*, and fetch_count unchanged.
//      Release -> pc = 6, if_id_pc = 5.
//  - redirect_valid = 1, redirect_pc = 0x10, same cycle as stall = 1 and a jump in IF:
//      pc = 0x10, if_id_valid = 0, if_id_inst = 0.
//  - Force pc = 0x3F, clean edge:
//      pc = 0x40, rom_addr = 0x00, if_id_pc = 0x3F.
//  - Assert rst mid-run between edges:
//      pc = RESET_PC, if_id_valid = 0, fetch_count = 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPCPU4 definitions: word width, opcode/jump field positions and predecode helpers.
package cpu_pkg;

    localparam int WORD_W  = 32;
    localparam int OPC_MSB = 31;
    localparam int OPC_LSB = 26;
    localparam int JMP_MSB = 25;
    localparam int JMP_LSB = 0;

    localparam logic [OPC_MSB-OPC_LSB:0] OP_JUMP = 6'h12;
    localparam logic [WORD_W-1:0]        NOP     = 32'h0;

    function automatic logic is_jump_op(input logic [WORD_W-1:0] inst);
        return inst[OPC_MSB:OPC_LSB] == OP_JUMP;
    endfunction

    // Jumps stay inside the current 64M-word region selected by the PC's top bits.
    function automatic logic [WORD_W-1:0] jump_target(input logic [WORD_W-1:0] pc,
                                                      input logic [WORD_W-1:0] inst);
        return {pc[WORD_W-1:JMP_MSB+1], inst[JMP_MSB:JMP_LSB]};
    endfunction

endpackage

// File: rtl/if_pc_reg.sv
// Fetch PC register: redirect beats stall, stall beats jump/sequential advance.
module if_pc_reg
    import cpu_pkg::*;
#(
    parameter logic [WORD_W-1:0] RESET_PC = 32'h0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic              redirect_valid,
    input  logic [WORD_W-1:0] redirect_pc,
    input  logic              is_jump,
    input  logic [WORD_W-1:0] jump_target,
    output logic [WORD_W-1:0] pc
);

    logic [WORD_W-1:0] r_pc;
    logic [WORD_W-1:0] w_pc_next;

    always_comb begin
        w_pc_next = r_pc;
        if (redirect_valid)
            w_pc_next = redirect_pc;
        else if (!stall)
            w_pc_next = is_jump ? jump_target : r_pc + 32'd1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_pc <= RESET_PC;
        else
            r_pc <= w_pc_next;
    end

    assign pc = r_pc;

endmodule

// File: rtl/if_stage.sv
// CPCPU4 instruction-fetch stage: drives ROM address, resolves jumps in IF, fills the IF/ID register.
module if_stage
    import cpu_pkg::*;
#(
    parameter int                ADDR_W   = 6,
    parameter logic [WORD_W-1:0] RESET_PC = 32'h0
) (
    input  logic              clk,
    input  logic              rst,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [WORD_W-1:0] rom_inst,
    input  logic              stall,
    input  logic              redirect_valid,
    input  logic [WORD_W-1:0] redirect_pc,
    output logic [WORD_W-1:0] pc,
    output logic [WORD_W-1:0] if_id_inst,
    output logic [WORD_W-1:0] if_id_pc,
    output logic [WORD_W-1:0] if_id_pc_plus1,
    output logic              if_id_valid,
    output logic              if_id_jumped,
    output logic [WORD_W-1:0] fetch_count
);

    logic [WORD_W-1:0] w_pc;
    logic              w_is_jump;
    logic [WORD_W-1:0] w_jump_target;
    logic              w_advance;

    logic [WORD_W-1:0] r_inst;
    logic [WORD_W-1:0] r_pc;
    logic [WORD_W-1:0] r_pc_plus1;
    logic              r_valid;
    logic              r_jumped;
    logic [WORD_W-1:0] r_fetch_count;

    assign w_is_jump     = is_jump_op(rom_inst);
    assign w_jump_target = jump_target(w_pc, rom_inst);
    assign w_advance     = !redirect_valid && !stall;

    if_pc_reg #(
        .RESET_PC(RESET_PC)
    ) u_pc_reg (
        .clk           (clk),
        .rst           (rst),
        .stall         (stall),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .is_jump       (w_is_jump),
        .jump_target   (w_jump_target),
        .pc            (w_pc)
    );

    // A redirect bubbles the slot but keeps the pc fields of the last real fetch.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_inst     <= NOP;
            r_pc       <= '0;
            r_pc_plus1 <= '0;
            r_valid    <= 1'b0;
            r_jumped   <= 1'b0;
        end else if (redirect_valid) begin
            r_inst   <= NOP;
            r_valid  <= 1'b0;
            r_jumped <= 1'b0;
        end else if (!stall) begin
            r_inst     <= rom_inst;
            r_pc       <= w_pc;
            r_pc_plus1 <= w_pc + 32'd1;
            r_valid    <= 1'b1;
            r_jumped   <= w_is_jump;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_fetch_count <= '0;
        else if (w_advance && (r_fetch_count != '1))
            r_fetch_count <= r_fetch_count + 32'd1;
    end

    assign rom_addr       = w_pc[ADDR_W-1:0];
    assign pc             = w_pc;
    assign if_id_inst     = r_inst;
    assign if_id_pc       = r_pc;
    assign if_id_pc_plus1 = r_pc_plus1;
    assign if_id_valid    = r_valid;
    assign if_id_jumped   = r_jumped;
    assign fetch_count    = r_fetch_count;

endmodule
